vga_pixel_reader: RTL and testbench

- Video output controller in the pixel_clk domain: generates HS/VS/BLANK timing for the 800x480 panel and drives RGB.
- Reads pixels from the read side of the dual-clock pixel FIFO; the sys_clk side is filled from SDRAM over Wishbone.
- Sits between that FIFO and hws_ifm video outputs; includes its own reset synchronizer, streaming FSM and underrun detection.

---
 rtl/vga_pixel_reader.sv | 127 ++++++++++++
 tb/tb_vga_pixel_reader.sv | 173 +++++++++++++++++
 2 files changed

// File: rtl/vga_pixel_reader.sv
// vga_pixel_reader: VGA timing generator streaming {R,G,B} from a show-ahead FIFO, sticky underrun flag.
// Define VGA_TEST_PATTERN_EN to add a test_mode input that replaces FIFO video with 8 colour bars.
module vga_pixel_reader #(
    parameter int HDISP  = 800,
    parameter int HFP    = 40,
    parameter int HPULSE = 48,
    parameter int HBP    = 40,
    parameter int VDISP  = 480,
    parameter int VFP    = 13,
    parameter int VPULSE = 3,
    parameter int VBP    = 29
) (
    input  logic        pixel_clk,
    input  logic        sys_rst,
    input  logic [23:0] fifo_rdata,
    input  logic        fifo_rempty,
    input  logic        fifo_wfull,
    output logic        fifo_read,
    output logic        vga_clk,
    output logic        vga_hs,
    output logic        vga_vs,
    output logic        vga_blank,
    output logic [7:0]  vga_r,
    output logic [7:0]  vga_g,
    output logic [7:0]  vga_b,
    output logic        underrun
`ifdef VGA_TEST_PATTERN_EN
    ,
    input  logic        test_mode
`endif
);
    localparam int HTOT = HFP + HPULSE + HBP + HDISP;
    localparam int VTOT = VFP + VPULSE + VBP + VDISP;
    localparam int HW = $clog2(HTOT);
    localparam int VW = $clog2(VTOT);
    localparam logic [HW-1:0] H_SYNC = HW'(HFP);
    localparam logic [HW-1:0] H_BP   = HW'(HFP + HPULSE);
    localparam logic [HW-1:0] H_ACT  = HW'(HFP + HPULSE + HBP);
    localparam logic [HW-1:0] H_LAST = HW'(HTOT - 1);
    localparam logic [VW-1:0] V_SYNC = VW'(VFP);
    localparam logic [VW-1:0] V_BP   = VW'(VFP + VPULSE);
    localparam logic [VW-1:0] V_ACT  = VW'(VFP + VPULSE + VBP);
    localparam logic [VW-1:0] V_LAST = VW'(VTOT - 1);
    localparam logic [1:0] WAIT_FILL  = 2'd0;
    localparam logic [1:0] WAIT_FRAME = 2'd1;
    localparam logic [1:0] STREAM     = 2'd2;

    logic [1:0]    rst_sync;
    logic          pixel_rst;
    logic [1:0]    wfull_sync;
    logic          wfull_s;
    logic [HW-1:0] hcnt;
    logic [VW-1:0] vcnt;
    logic [1:0]    state, state_next;
    logic          h_last, v_last, active, starve, test_on;
    logic [23:0]   pixel;

    assign vga_clk = ~pixel_clk;

    always_ff @(posedge pixel_clk or posedge sys_rst)
        if (sys_rst) rst_sync <= 2'b11;
        else rst_sync <= {rst_sync[0], 1'b0};
    assign pixel_rst = rst_sync[1];

    always_ff @(posedge pixel_clk or posedge pixel_rst)
        if (pixel_rst) wfull_sync <= 2'b00;
        else wfull_sync <= {wfull_sync[0], fifo_wfull};
    assign wfull_s = wfull_sync[1];

    assign h_last = hcnt == H_LAST;
    assign v_last = vcnt == V_LAST;

    always_ff @(posedge pixel_clk or posedge pixel_rst)
        if (pixel_rst) begin
            hcnt <= '0;
            vcnt <= '0;
        end else begin
            hcnt <= h_last ? '0 : hcnt + 1'b1;
            if (h_last) vcnt <= v_last ? '0 : vcnt + 1'b1;
        end

`ifdef VGA_TEST_PATTERN_EN
    assign test_on = test_mode;
`else
    assign test_on = 1'b0;
`endif

    assign active    = hcnt >= H_ACT && vcnt >= V_ACT;
    assign starve    = state == STREAM && active && fifo_rempty && !test_on;
    assign fifo_read = state == STREAM && active && !fifo_rempty && !test_on;

    // Streaming only starts at a frame boundary so the first word popped lands on the frame origin.
    always_comb
        state_next = test_on                ? WAIT_FILL :
                     state == WAIT_FILL     ? (wfull_s ? WAIT_FRAME : WAIT_FILL) :
                     state == WAIT_FRAME    ? (h_last && v_last ? STREAM : WAIT_FRAME) :
                     state == STREAM && !starve ? STREAM : WAIT_FILL;

`ifdef VGA_TEST_PATTERN_EN
    logic [HW-1:0] hoff;
    logic [2:0]    bar;
    assign hoff  = hcnt - H_ACT;
    assign bar   = 3'(hoff / HW'(HDISP / 8));
    // Bar index bits map straight to colour: R off for bars 2,3,6,7; G off for 4..7; B off for odd bars.
    assign pixel = test_mode ? {{8{~bar[1]}}, {8{~bar[2]}}, {8{~bar[0]}}} :
                   fifo_read ? fifo_rdata : 24'h0;
`else
    assign pixel = fifo_read ? fifo_rdata : 24'h0;
`endif

    always_ff @(posedge pixel_clk or posedge pixel_rst)
        if (pixel_rst) begin
            state     <= WAIT_FILL;
            underrun  <= 1'b0;
            vga_hs    <= 1'b1;
            vga_vs    <= 1'b1;
            vga_blank <= 1'b0;
            {vga_r, vga_g, vga_b} <= 24'h0;
        end else begin
            state     <= state_next;
            underrun  <= underrun | starve;
            vga_hs    <= !(hcnt >= H_SYNC && hcnt < H_BP);
            vga_vs    <= !(vcnt >= V_SYNC && vcnt < V_BP);
            vga_blank <= active;
            {vga_r, vga_g, vga_b} <= active ? pixel : 24'h0;
        end
endmodule

// File: tb/tb_vga_pixel_reader.sv
// tb_vga_pixel_reader: randomized bench for vga_pixel_reader on a 14x7 raster with a frame-level reference model.
// Exercises VGA_TEST_PATTERN_EN colour bars as well when that macro is defined.
module tb_vga_pixel_reader;
    localparam int HDISP = 8, HFP = 2, HPULSE = 2, HBP = 2;
    localparam int VDISP = 4, VFP = 1, VPULSE = 1, VBP = 1;
    localparam int HTOT = HFP + HPULSE + HBP + HDISP;
    localparam int VTOT = VFP + VPULSE + VBP + VDISP;
    localparam int FTOT = HTOT * VTOT;
    localparam int HSTART = HTOT - HDISP;
    localparam int VSTART = VTOT - VDISP;

    logic        pixel_clk = 1'b0;
    logic        sys_rst = 1'b0;
    logic        fifo_rempty = 1'b1;
    logic        fifo_wfull = 1'b0;
    logic        test_mode = 1'b0;
    logic [23:0] fifo_rdata = 24'h0;
    logic        fifo_read, vga_clk, vga_hs, vga_vs, vga_blank, underrun;
    logic [7:0]  vga_r, vga_g, vga_b;

    vga_pixel_reader #(
        .HDISP(HDISP), .HFP(HFP), .HPULSE(HPULSE), .HBP(HBP),
        .VDISP(VDISP), .VFP(VFP), .VPULSE(VPULSE), .VBP(VBP)
    ) dut (
        .pixel_clk(pixel_clk), .sys_rst(sys_rst), .fifo_rdata(fifo_rdata),
        .fifo_rempty(fifo_rempty), .fifo_wfull(fifo_wfull), .fifo_read(fifo_read),
        .vga_clk(vga_clk), .vga_hs(vga_hs), .vga_vs(vga_vs), .vga_blank(vga_blank),
        .vga_r(vga_r), .vga_g(vga_g), .vga_b(vga_b), .underrun(underrun)
`ifdef VGA_TEST_PATTERN_EN
        , .test_mode(test_mode)
`endif
    );

    always #15 pixel_clk = ~pixel_clk;

    int vectors = 0, errors = 0;
    int t = 0, stream_from = -1;
    int hs_fall, hs_lows, vs_lows, blank_cnt, dut_reads;
    logic e_hs, e_vs, e_blank, e_under, e_read;
    logic [23:0] e_rgb;
    logic wf_log [0:4095];
    logic [23:0] q [$];
    logic [23:0] next_val = 24'h0;
    logic wf_drive = 1'b0, force_empty = 1'b0, rand_data = 1'b0;
    logic [23:0] bars [0:7] = '{24'hFFFFFF, 24'hFFFF00, 24'h00FFFF, 24'h00FF00,
                                24'hFF00FF, 24'hFF0000, 24'h0000FF, 24'h000000};

    task automatic check(input string tag, input logic [23:0] got, input logic [23:0] exp);
        vectors++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h, expected %h (t=%0d)", tag, got, exp, t);
        end
    endtask

    task automatic do_reset();
        @(negedge pixel_clk);
        sys_rst = 1'b1;
        #1;
        check("rst_hs", 24'(vga_hs), 24'(1));
        check("rst_vs", 24'(vga_vs), 24'(1));
        check("rst_blank", 24'(vga_blank), 24'(0));
        check("rst_rgb", {vga_r, vga_g, vga_b}, 24'h0);
        check("rst_read", 24'(fifo_read), 24'(0));
        check("rst_underrun", 24'(underrun), 24'(0));
        @(negedge pixel_clk);
        sys_rst = 1'b0;
        repeat (2) @(posedge pixel_clk);
        t = 0; stream_from = -1;
        e_hs = 1'b1; e_vs = 1'b1; e_blank = 1'b0; e_rgb = 24'h0; e_under = 1'b0;
        hs_fall = -1; hs_lows = 0; vs_lows = 0; blank_cnt = 0;
    endtask

    // One pixel: check last cycle's registered outputs, drive inputs, then predict this cycle.
    task automatic cycle();
        int h, v;
        logic act, strm, wfs;
        @(negedge pixel_clk);
        check("vga_hs", 24'(vga_hs), 24'(e_hs));
        check("vga_vs", 24'(vga_vs), 24'(e_vs));
        check("vga_blank", 24'(vga_blank), 24'(e_blank));
        check("rgb", {vga_r, vga_g, vga_b}, e_rgb);
        check("underrun", 24'(underrun), 24'(e_under));
        check("vga_clk", 24'(vga_clk), 24'(!pixel_clk));
        if (t >= 1 && t <= FTOT) begin
            hs_lows += int'(!vga_hs);
            vs_lows += int'(!vga_vs);
            blank_cnt += int'(vga_blank);
        end
        if (!vga_hs && hs_fall < 0) hs_fall = t;
        if (t == FTOT + 1) begin
            check("hs_first_fall", 24'(hs_fall), 24'(HFP + 1));
            check("hs_low_per_frame", 24'(hs_lows), 24'(HPULSE * VTOT));
            check("vs_low_per_frame", 24'(vs_lows), 24'(VPULSE * HTOT));
            check("blank_per_frame", 24'(blank_cnt), 24'(HDISP * VDISP));
        end
        while (q.size() < 4) begin
            q.push_back(rand_data ? 24'($urandom) : next_val);
            next_val++;
        end
        fifo_wfull = wf_drive;
        fifo_rempty = force_empty;
        fifo_rdata = force_empty ? 24'($urandom) : q[0];
        #1;
        h = t % HTOT;
        v = (t / HTOT) % VTOT;
        act = h >= HSTART && v >= VSTART;
        wfs = (t >= 2) ? wf_log[t - 2] : 1'b0;
        strm = stream_from >= 0 && t >= stream_from;
        e_read = strm && act && !fifo_rempty && !test_mode;
        check("fifo_read", 24'(fifo_read), 24'(e_read));
        dut_reads += int'(fifo_read);
        e_hs = !(h >= HFP && h < HFP + HPULSE);
        e_vs = !(v >= VFP && v < VFP + VPULSE);
        e_blank = act;
        e_rgb = e_read ? fifo_rdata : 24'h0;
        if (test_mode && act) e_rgb = bars[(h - HSTART) / (HDISP / 8)];
        if (strm && act && fifo_rempty) begin
            e_under = 1'b1;
            stream_from = -1;
        end else if (stream_from < 0 && wfs && !test_mode)
            stream_from = ((t + 1) / FTOT + 1) * FTOT;
        if (e_read) void'(q.pop_front());
        if (t < 4096) wf_log[t] = fifo_wfull;
        t++;
    endtask

    initial begin
        do_reset();
        dut_reads = 0;
        repeat (3 * FTOT) cycle();
        check("reads_while_unfilled", 24'(dut_reads), 24'(0));
        repeat (40) cycle();
        wf_drive = 1'b1;
        while (t < 4 * FTOT) cycle();
        dut_reads = 0;
        repeat (FTOT) cycle();
        check("reads_first_frame", 24'(dut_reads), 24'(HDISP * VDISP));
        while (t < 5 * FTOT + VSTART * HTOT + HSTART + 3) cycle();
        force_empty = 1'b1;
        cycle();
        force_empty = 1'b0;
        dut_reads = 0;
        while (t < 6 * FTOT) cycle();
        check("reads_after_underrun", 24'(dut_reads), 24'(0));
        check("underrun_sticky", 24'(underrun), 24'(1));
        dut_reads = 0;
        repeat (FTOT) cycle();
        check("reads_resumed_frame", 24'(dut_reads), 24'(HDISP * VDISP));
        rand_data = 1'b1;
        repeat (6 * FTOT) begin
            if ($urandom_range(0, 29) == 0) wf_drive = !wf_drive;
            force_empty = $urandom_range(0, 39) == 0;
            cycle();
        end
        repeat ($urandom_range(HSTART, HTOT - 1)) cycle();
        force_empty = 1'b0;
        wf_drive = 1'b1;
        do_reset();
        repeat (3 * FTOT) begin
            force_empty = $urandom_range(0, 99) == 0;
            cycle();
        end
`ifdef VGA_TEST_PATTERN_EN
        force_empty = 1'b0;
        test_mode = 1'b1;
        do_reset();
        repeat (2 * FTOT) cycle();
`endif
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end
endmodule
